seq1011_frame_tx: RTL and testbench

Serial frame transmitter that drives the single-bit stream consumed by the overlapping 1011 Mealy detector. Accepts one PAYLOAD_W-bit word per frame over a valid/ready handshake. Emits the sync word 1011, the payload MSB-first with zero-bit stuffing so that 1011 never appears outside the sync word, then one guard 0. Sits upstream of the detector in loopback benches and link-level tests.

---
 rtl/seq1011_pkg.sv | 26 ++
 rtl/seq1011_frame_tx_if.sv | 26 ++
 rtl/seq1011_tx_stuff.sv | 37 +++
 rtl/seq1011_frame_tx.sv | 132 +++++++++++++
 tb/tb_seq1011_frame_tx.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq1011_pkg.sv
// rtl/seq1011_pkg.sv - shared constants and state type for the 1011 framing link
//
// Purpose: one place for the sync word and framing constants, so the
// transmitter and the detector agree on them.
// Contents: SYNC_WORD, SYNC_LEN, HIST_INIT, tx_state_e, sync_bit().
package seq1011_pkg;

    localparam logic [3:0] SYNC_WORD = 4'b1011;
    localparam int         SYNC_LEN  = 4;
    // The last three sync bits. After a sync word, the history register
    // holds this value.
    localparam logic [2:0] HIST_INIT = 3'b011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        PAYLOAD = 2'd2,
        GUARD   = 2'd3
    } tx_state_e;

    // Returns sync bit number idx. Bits are numbered from 0 and sent MSB first.
    function automatic logic sync_bit(input logic [1:0] idx);
        sync_bit = SYNC_WORD[2'd3 - idx];
    endfunction

endpackage

// File: rtl/seq1011_frame_tx_if.sv
// rtl/seq1011_frame_tx_if.sv - payload handshake and serial line bundle for seq1011_frame_tx
//
// Purpose: groups the signals of the payload word handshake with the serial
// frame outputs.
// Signals: s_valid, s_ready, s_data[PAYLOAD_W], dout, busy, frame_done.
// Modports: master (the source of payload words), slave (the transmitter).
interface seq1011_frame_tx_if #(
    parameter int PAYLOAD_W = 8
);
    logic                 s_valid;
    logic                 s_ready;
    logic [PAYLOAD_W-1:0] s_data;
    logic                 dout;
    logic                 busy;
    logic                 frame_done;

    modport master (
        output s_valid, s_data,
        input  s_ready, dout, busy, frame_done
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, dout, busy, frame_done
    );
endinterface

// File: rtl/seq1011_tx_stuff.sv
// rtl/seq1011_tx_stuff.sv - history of the last three bits and the stuff decision
//
// Purpose: keeps the last three bits sent on the line. It raises stuff_now
// when those bits are 101, because one more 1 after them would form 1011.
// The module is compiled only when SEQ1011_TX_STUFF_EN is defined.
// Ports: clk, rst (synchronous, active-high), load_init (load HIST_INIT),
//        shift_en/bit_in (shift one sent bit in), stuff_now (out).
`ifdef SEQ1011_TX_STUFF_EN
module seq1011_tx_stuff
    import seq1011_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load_init,
    input  logic shift_en,
    input  logic bit_in,
    output logic stuff_now
);

    logic [2:0] hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 3'b000;
        end else if (load_init) begin
            hist <= HIST_INIT;
        end else if (shift_en) begin
            hist <= {hist[1:0], bit_in};
        end
    end

    // History matches the first three sync bits (101). Sending a 0 now
    // breaks up any 1011 that could form outside the sync word.
    assign stuff_now = (hist == SYNC_WORD[3:1]);

endmodule
`endif

// File: rtl/seq1011_frame_tx.sv
// rtl/seq1011_frame_tx.sv - serial frame transmitter: sync 1011, stuffed payload, guard 0
//
// Purpose: accepts one PAYLOAD_W-bit word per frame. It sends the sync word
// 1011, then the payload MSB first, then one guard 0. With
// SEQ1011_TX_STUFF_EN defined, a 0 is inserted whenever the last three
// bits sent are 101, so 1011 appears only in the sync word. Without the
// macro, the payload is sent raw.
// Ports: clk, rst (synchronous, active-high),
//        bus (seq1011_frame_tx_if.slave): s_valid/s_ready/s_data in,
//        dout (registered serial line), busy, frame_done (pulse on the guard bit).
module seq1011_frame_tx
    import seq1011_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq1011_frame_tx_if.slave  bus
);

    localparam int                CNT_W    = $clog2(PAYLOAD_W + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PAYLOAD_W);

    // 'state' is the phase of the bit that dout is carrying now.
    tx_state_e            state;
    logic [PAYLOAD_W-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;   // payload bits consumed; stuffed bits are not counted
    logic [2:0]           sync_cnt;  // sync bits already sent
    logic                 dout_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 s_ready;
    logic                 xfer;
    logic                 emit;
    logic                 stuff_now;
    logic                 next_bit;

    assign s_ready = !rst && (state == IDLE || state == GUARD);
    assign xfer    = bus.s_valid && s_ready;

    // emit is high at every edge that puts a payload slot on the line. A
    // payload slot is either a payload bit or a stuffed 0. The first slot
    // follows the fourth sync bit.
    assign emit = (state == SYNC && sync_cnt == 3'(SYNC_LEN)) ||
                  (state == PAYLOAD && bit_cnt != LAST_CNT);

    assign next_bit = stuff_now ? 1'b0 : shreg[PAYLOAD_W-1];

`ifdef SEQ1011_TX_STUFF_EN
    logic load_init;

    // The history is loaded while the last sync bit is sent. The first
    // payload decision then sees HIST_INIT.
    assign load_init = (state == SYNC) && (sync_cnt == 3'(SYNC_LEN - 1));

    seq1011_tx_stuff u_stuff (
        .clk       (clk),
        .rst       (rst),
        .load_init (load_init),
        .shift_en  (emit),
        .bit_in    (next_bit),
        .stuff_now (stuff_now)
    );
`else
    assign stuff_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            sync_cnt <= '0;
            dout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, GUARD: begin
                    // A word accepted during the guard cycle starts the next
                    // sync word straight away, with no idle gap.
                    if (xfer) begin
                        shreg    <= bus.s_data;
                        bit_cnt  <= '0;
                        sync_cnt <= 3'd1;
                        dout_q   <= SYNC_WORD[3];
                        busy_q   <= 1'b1;
                        state    <= SYNC;
                    end else begin
                        dout_q <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                SYNC: begin
                    if (sync_cnt != 3'(SYNC_LEN)) begin
                        dout_q   <= sync_bit(sync_cnt[1:0]);
                        sync_cnt <= sync_cnt + 3'd1;
                    end else begin
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (bit_cnt == LAST_CNT) begin
                        dout_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= GUARD;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (emit) begin
                dout_q <= next_bit;
                if (!stuff_now) begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.s_ready    = s_ready;
    assign bus.dout       = dout_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_seq1011_frame_tx.sv
// tb/tb_seq1011_frame_tx.sv - self-checking bench for seq1011_frame_tx
//
// Purpose: sends directed and random payload words and compares each frame on
// dout with a bit-stream reference model. The model follows the define
// SEQ1011_TX_STUFF_EN. The bench also runs a 1011 detector on dout.
module tb_seq1011_frame_tx;

    localparam int PW = 8;

`ifdef SEQ1011_TX_STUFF_EN
    localparam bit STUFF = 1'b1;
`else
    localparam bit STUFF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq1011_frame_tx_if #(.PAYLOAD_W(PW)) bus ();

    seq1011_frame_tx #(.PAYLOAD_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference frame: the sync word, then the payload MSB first, then a 0.
    // With stuffing, a 0 is placed before any payload bit whose three
    // preceding stream bits are 1,0,1.
    function automatic void build_frame(input logic [PW-1:0] d, output bit [63:0] bits, output int len);
        bits = '0;
        bits[0] = 1'b1; bits[1] = 1'b0; bits[2] = 1'b1; bits[3] = 1'b1;
        len = 4;
        for (int i = PW - 1; i >= 0; i--) begin
            if (STUFF && bits[len-3] && !bits[len-2] && bits[len-1]) begin
                bits[len] = 1'b0;
                len++;
            end
            bits[len] = d[i];
            len++;
        end
        bits[len] = 1'b0;
        len++;
    endfunction

    // Monitor state
    int              cyc = 0;
    bit [63:0]       cur;
    int              cur_len = 0;
    int              last_len = 0;
    logic [3:0]      det = 4'b0000;
    int              total_hits = 0;
    int              hits_in = 0;
    int              hit_pos = 0;
    int              frames_done = 0;
    logic [PW-1:0]   exp_data_q[$];
    int              exp_start_q[$];

    always @(posedge clk) begin
        logic r;
        r = rst;
        #1;
        cyc++;
        det = {det[2:0], bus.dout};
        if (det == 4'b1011) total_hits++;
        if (r) begin
            cur_len = 0;
            hits_in = 0;
        end else begin
            if (bus.busy) begin
                if (cur_len == 0) begin
                    if (exp_start_q.size() == 0) check_eq("unexpected_start", 0, 1);
                    else check_eq("start_cyc", cyc, exp_start_q.pop_front());
                end
                if (cur_len < 64) cur[cur_len] = bus.dout;
                cur_len++;
                if (det == 4'b1011) begin
                    hits_in++;
                    hit_pos = cur_len;
                end
            end
            if (bus.frame_done) begin
                bit [63:0] eb;
                int        el;
                int        errs;
                check_eq("done_while_busy", {31'd0, bus.busy}, 1);
                if (exp_data_q.size() == 0) begin
                    check_eq("unexpected_done", 0, 1);
                end else begin
                    build_frame(exp_data_q.pop_front(), eb, el);
                    check_eq("frame_len", cur_len, el);
                    errs = 0;
                    for (int i = 0; i < el && i < 64; i++)
                        if (cur[i] !== eb[i]) errs++;
                    check_eq("frame_bit_errs", errs, 0);
                    if (STUFF) begin
                        check_eq("hits_per_frame", hits_in, 1);
                        check_eq("hit_pos", hit_pos, 4);
                    end
                end
                frames_done++;
                last_len = cur_len;
                cur_len  = 0;
                hits_in  = 0;
            end
        end
    end

    // Offer a word from a falling edge and wait until it is accepted.
    // s_valid is left high so that a following send() is back-to-back.
    task automatic send(input logic [PW-1:0] d);
        int budget;
        budget = 0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        #1;
        while (!bus.s_ready && budget < 100) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (bus.s_ready) begin
            exp_data_q.push_back(d);
            exp_start_q.push_back(cyc + 1);
        end else begin
            check_eq("send_timeout", 0, 1);
            bus.s_valid = 1'b0;
        end
    endtask

    // Drop s_valid and scramble s_data; the held word must be unaffected.
    task automatic idle(input int n);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data  = PW'($urandom);
        for (int i = 1; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        while ((bus.busy || exp_data_q.size() != 0) && b < 200) begin
            @(negedge clk);
            b++;
        end
        check_eq("drain_in_time", {31'd0, (b < 200)}, 1);
        @(negedge clk);
        check_eq("idle_dout", {31'd0, bus.dout}, 0);
        check_eq("idle_busy", {31'd0, bus.busy}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [PW-1:0] dir_words [3];
        int            dir_lens  [3];
        int            fd0;
        int            h0;
        int            b;
        int            gap;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_dout",   {31'd0, bus.dout}, 0);
        check_eq("rst_busy",   {31'd0, bus.busy}, 0);
        check_eq("rst_done",   {31'd0, bus.frame_done}, 0);
        check_eq("rst_sready", {31'd0, bus.s_ready}, 0);
        rst = 1'b0;
        #1;
        check_eq("idle_sready", {31'd0, bus.s_ready}, 1);

        // Directed frames with known lengths
        dir_words[0] = 8'hA5; dir_lens[0] = STUFF ? 14 : 13;
        dir_words[1] = 8'h00; dir_lens[1] = 13;
        dir_words[2] = 8'hFF; dir_lens[2] = 13;
        for (int i = 0; i < 3; i++) begin
            fd0 = frames_done;
            send(dir_words[i]);
            idle(1);
            wait_done();
            check_eq("dir_frames", frames_done, fd0 + 1);
            check_eq("dir_len", last_len, dir_lens[i]);
        end

        // Back-to-back: the second word is accepted in the guard cycle
        fd0 = frames_done;
        h0  = total_hits;
        send(8'hA5);
        send(8'h5A);
        idle(1);
        wait_done();
        check_eq("b2b_frames", frames_done, fd0 + 2);
        if (STUFF) check_eq("b2b_hits", total_hits, h0 + 2);

        // Reset during the third payload bit of A5
        fd0 = frames_done;
        send(8'hA5);
        idle(1);
        b = 0;
        while (cur_len != 7 && b < 50) begin
            @(negedge clk);
            b++;
        end
        check_eq("abort_reached", cur_len, 7);
        rst = 1'b1;
        exp_data_q.delete();
        exp_start_q.delete();
        @(negedge clk);
        check_eq("abort_dout",   {31'd0, bus.dout}, 0);
        check_eq("abort_busy",   {31'd0, bus.busy}, 0);
        check_eq("abort_done",   {31'd0, bus.frame_done}, 0);
        check_eq("abort_sready", {31'd0, bus.s_ready}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("abort_no_done", frames_done, fd0);
        h0 = total_hits;
        send(8'h0F);
        idle(1);
        wait_done();
        check_eq("post_abort_frames", frames_done, fd0 + 1);
        if (STUFF) check_eq("post_abort_hits", total_hits, h0 + 1);

        // Random words with random gaps. A gap of 0 means back-to-back.
        fd0 = frames_done;
        for (int i = 0; i < 40; i++) begin
            send(PW'($urandom));
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(gap);
        end
        idle(1);
        wait_done();
        check_eq("rand_frames", frames_done, fd0 + 40);
        check_eq("rand_queue_empty", exp_data_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
